cmd_paralelo_serial: RTL and testbench

Parallel-to-serial transmitter for the SD host CMD line, on the physical layer next to the serial-to-parallel receiver. It accepts a command index and argument from the command layer and builds the 48-bit SD command frame: start bit, transmission bit, index, argument, CRC7 and end bit. It shifts the frame MSB-first onto the CMD line on `sd_clock` and drives an output-enable for the bidirectional pad. The CRC7 is computed on the fly, so the command layer never handles it.

---
 rtl/sd_cmd_pkg.sv | 34 +++
 rtl/cmd_paralelo_serial_if.sv | 23 ++
 rtl/cmd_crc7.sv | 39 +++
 rtl/cmd_paralelo_serial.sv | 158 +++++++++++++++
 tb/tb_cmd_paralelo_serial.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/sd_cmd_pkg.sv
// Shared SD CMD-line constants, state encoding and the CRC7 step function.
// The serial-to-parallel receiver and the receive-side CRC checker use this package too.
package sd_cmd_pkg;

  localparam int CMD_INDEX_W = 6;
  localparam int CMD_ARG_W   = 32;
  localparam int CMD_CRC_W   = 7;
  localparam int CMD_FRAME_W = 1 + 1 + CMD_INDEX_W + CMD_ARG_W + CMD_CRC_W + 1;

  localparam logic START_BIT = 1'b0;
  localparam logic TX_BIT    = 1'b1;
  localparam logic END_BIT   = 1'b1;

  // x^7 + x^3 + 1
  localparam logic [CMD_CRC_W-1:0] CMD_CRC_POLY = 7'h09;

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
    CRC,
    END,
    DONE
  } cmd_state_e;

  // One serial CRC7 step for input bit b.
  function automatic logic [CMD_CRC_W-1:0] crc7_step(input logic [CMD_CRC_W-1:0] crc,
                                                     input logic                 b,
                                                     input logic [CMD_CRC_W-1:0] poly);
    logic fb;
    fb = b ^ crc[CMD_CRC_W-1];
    return {crc[CMD_CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
  endfunction

endpackage

// File: rtl/cmd_paralelo_serial_if.sv
// Command-layer <-> CMD transmitter bundle: request, captured fields and line outputs.
interface cmd_paralelo_serial_if #(
  parameter int INDEX_W = 6,
  parameter int ARG_W   = 32
);
  logic               start;
  logic [INDEX_W-1:0] cmd_index;
  logic [ARG_W-1:0]   argument;
  logic               serial;
  logic               cmd_oe;
  logic               busy;
  logic               done;

  modport master (
    output start, cmd_index, argument,
    input  serial, cmd_oe, busy, done
  );

  modport slave (
    input  start, cmd_index, argument,
    output serial, cmd_oe, busy, done
  );
endinterface

// File: rtl/cmd_crc7.sv
// Serial CRC7 register. enable feeds one data bit; shift streams the remainder out MSB-first
// with feedback frozen. clear zeroes the register and may coincide with enable, so the first
// bit of a frame is folded in on the same edge the register is cleared.
module cmd_crc7
  import sd_cmd_pkg::*;
#(
  parameter logic [CMD_CRC_W-1:0] POLY = CMD_CRC_POLY
) (
  input  logic sd_clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic shift,
  input  logic data_in,
  output logic crc_msb
);

  logic [CMD_CRC_W-1:0] crc_q;
  logic [CMD_CRC_W-1:0] base;

  // Starting point for this edge: zero when clearing, else the held remainder.
  always_comb base = clear ? '0 : crc_q;

  // Feed, shift out, or hold the remainder.
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      crc_q <= '0;
    end else if (enable) begin
      crc_q <= crc7_step(base, data_in, POLY);
    end else if (shift) begin
      crc_q <= {base[CMD_CRC_W-2:0], 1'b0};
    end else begin
      crc_q <= base;
    end
  end

  assign crc_msb = crc_q[CMD_CRC_W-1];

endmodule

// File: rtl/cmd_paralelo_serial.sv
// SD host CMD-line transmitter: builds start/tx/index/argument/CRC7/end and shifts it out MSB-first.
//
// state   | meaning
// IDLE    | line released, waiting for start
// PAYLOAD | start bit, tx bit, index, argument on the line
// CRC     | 7 CRC bits on the line
// END     | end bit on the line
// DONE    | line released, done pulse
//
// Every output is a flop. Each cycle the output logic computes what the line carries in the
// NEXT cycle, so on the acceptance edge the start bit is already loaded into serial, and each
// bit is folded into the CRC on the same edge it is put on the line.
module cmd_paralelo_serial
  import sd_cmd_pkg::*;
#(
  parameter int                   INDEX_W  = CMD_INDEX_W,
  parameter int                   ARG_W    = CMD_ARG_W,
  parameter logic [CMD_CRC_W-1:0] CRC_POLY = CMD_CRC_POLY
) (
  input logic                  sd_clock,
  input logic                  reset,
  cmd_paralelo_serial_if.slave bus
);

  localparam int PAYLOAD_BITS = 2 + INDEX_W + ARG_W;
  localparam int LONGEST      = (PAYLOAD_BITS > CMD_CRC_W) ? PAYLOAD_BITS : CMD_CRC_W;
  localparam int CNT_W        = $clog2(LONGEST);
  localparam logic [CNT_W-1:0] PAYLOAD_LAST = CNT_W'(PAYLOAD_BITS - 1);
  localparam logic [CNT_W-1:0] CRC_LAST     = CNT_W'(CMD_CRC_W - 1);

  cmd_state_e              state, state_next;
  logic [CNT_W-1:0]        cnt;
  logic [PAYLOAD_BITS-1:0] shreg, payload_in;
  logic                    last;
  logic                    serial_q, cmd_oe_q, busy_q, done_q;
  logic                    serial_d, cmd_oe_d, busy_d, done_d;
  logic                    crc_clear, crc_en, crc_shift, crc_bit, crc_msb;

  assign payload_in = {START_BIT, TX_BIT, bus.cmd_index, bus.argument};

  // Final bit of the current segment is on the line.
  always_comb last = ((state == PAYLOAD) && (cnt == PAYLOAD_LAST)) ||
                     ((state == CRC)     && (cnt == CRC_LAST));

  // State register.
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode; start outside IDLE is dropped, not queued.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = PAYLOAD;
      PAYLOAD: if (last)      state_next = CRC;
      CRC:     if (last)      state_next = END;
      END:                    state_next = DONE;
      DONE:                   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Next-cycle line values and CRC controls.
  always_comb begin
    serial_d  = 1'b1;
    cmd_oe_d  = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    crc_clear = 1'b0;
    crc_en    = 1'b0;
    crc_shift = 1'b0;
    crc_bit   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          serial_d  = payload_in[PAYLOAD_BITS-1];
          cmd_oe_d  = 1'b1;
          busy_d    = 1'b1;
          crc_clear = 1'b1;
          crc_en    = 1'b1;
          crc_bit   = payload_in[PAYLOAD_BITS-1];
        end
      end
      PAYLOAD: begin
        cmd_oe_d = 1'b1;
        busy_d   = 1'b1;
        if (last) begin
          serial_d  = crc_msb;
          crc_shift = 1'b1;
        end else begin
          serial_d = shreg[PAYLOAD_BITS-2];
          crc_en   = 1'b1;
          crc_bit  = shreg[PAYLOAD_BITS-2];
        end
      end
      CRC: begin
        cmd_oe_d = 1'b1;
        busy_d   = 1'b1;
        if (last) begin
          serial_d = END_BIT;
        end else begin
          serial_d  = crc_msb;
          crc_shift = 1'b1;
        end
      end
      END: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Payload shifter and per-segment bit counter (cleared on every state change).
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else begin
      if ((state == IDLE) && bus.start) shreg <= payload_in;
      else if (state == PAYLOAD)        shreg <= {shreg[PAYLOAD_BITS-2:0], 1'b0};
      if ((state_next != state) || ((state != PAYLOAD) && (state != CRC))) cnt <= '0;
      else                                                                cnt <= cnt + 1'b1;
    end
  end

  // Registered line outputs.
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      serial_q <= 1'b1;
      cmd_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      serial_q <= serial_d;
      cmd_oe_q <= cmd_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  cmd_crc7 #(.POLY(CRC_POLY)) u_crc (
    .sd_clock (sd_clock),
    .reset    (reset),
    .clear    (crc_clear),
    .enable   (crc_en),
    .shift    (crc_shift),
    .data_in  (crc_bit),
    .crc_msb  (crc_msb)
  );

  assign bus.serial = serial_q;
  assign bus.cmd_oe = cmd_oe_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_cmd_paralelo_serial.sv
// Bench for cmd_paralelo_serial: known SD command vectors, random frames against a frame model,
// ignored starts mid-frame and in DONE, and an asynchronous reset mid-frame.
module tb_cmd_paralelo_serial;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [47:0] frame;
    string       name;
  } vec_t;

  logic sd_clock;
  logic reset;
  int   tests;
  int   fails;
  vec_t vecs[3];

  cmd_paralelo_serial_if #(.INDEX_W(6), .ARG_W(32)) bus ();

  cmd_paralelo_serial dut (
    .sd_clock (sd_clock),
    .reset    (reset),
    .bus      (bus)
  );

  initial begin
    sd_clock = 1'b0;
    forever #5 sd_clock = ~sd_clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Whole 48-bit frame for a command: fields, then CRC7 of the first 40 bits, then end bit.
  function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] p;
    logic [6:0]  c;
    logic        fb;
    p = {1'b0, 1'b1, idx, arg};
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = p[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return {p, c, 1'b1};
  endfunction

  // Called just after a negedge with the DUT idle; returns at the negedge of cycle k+50.
  task automatic run_frame(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] exp,
                           input string name, input int pulse_bit, input bit pulse_done,
                           input int reset_bit);
    logic [47:0] got;
    bit oe_ok, busy_ok, quiet, aborted;
    got = '0; oe_ok = 1'b1; busy_ok = 1'b1; quiet = 1'b1; aborted = 1'b0;
    bus.start     = 1'b1;
    bus.cmd_index = idx;
    bus.argument  = arg;
    @(posedge sd_clock);
    @(negedge sd_clock);
    bus.start     = 1'b0;
    bus.cmd_index = ~idx;
    bus.argument  = ~arg;
    for (int i = 0; i < 48 && !aborted; i++) begin
      if (i > 0) @(negedge sd_clock);
      got[47-i] = bus.serial;
      if (bus.cmd_oe !== 1'b1) oe_ok = 1'b0;
      if (bus.busy !== 1'b1)   busy_ok = 1'b0;
      if (bus.done !== 1'b0)   quiet = 1'b0;
      if (i == reset_bit) begin
        #1 reset = 1'b0;
        #1;
        check({name, "/rst_serial"}, 64'(bus.serial), 64'd1);
        check({name, "/rst_oe"},     64'(bus.cmd_oe), 64'd0);
        check({name, "/rst_busy"},   64'(bus.busy),   64'd0);
        check({name, "/rst_done"},   64'(bus.done),   64'd0);
        aborted = 1'b1;
      end else if (i == pulse_bit) begin
        bus.start     = 1'b1;
        bus.cmd_index = 6'($urandom);
        bus.argument  = $urandom;
      end else begin
        bus.start = 1'b0;
      end
    end
    if (!aborted) begin
      check({name, "/frame"},     64'(got),     64'(exp));
      check({name, "/oe_frame"},  64'(oe_ok),   64'd1);
      check({name, "/busy_frame"}, 64'(busy_ok), 64'd1);
      check({name, "/no_early_done"}, 64'(quiet), 64'd1);
      @(negedge sd_clock);
      check({name, "/done_cycle"}, {60'd0, bus.done, bus.busy, bus.cmd_oe, bus.serial}, 64'hD);
      if (pulse_done) begin
        bus.start     = 1'b1;
        bus.cmd_index = 6'($urandom);
        bus.argument  = $urandom;
      end
      @(negedge sd_clock);
      check({name, "/idle_after"}, {60'd0, bus.done, bus.busy, bus.cmd_oe, bus.serial}, 64'h1);
    end
  endtask

  initial begin
    logic [5:0]  ridx;
    logic [31:0] rarg;
    bit          seen;

    tests = 0;
    fails = 0;
    vecs[0] = '{idx: 6'd0,  arg: 32'h0000_0000, frame: 48'h40_0000_0000_95, name: "cmd0"};
    vecs[1] = '{idx: 6'd8,  arg: 32'h0000_01AA, frame: 48'h48_0000_01AA_87, name: "cmd8"};
    vecs[2] = '{idx: 6'd17, arg: 32'h0000_0000, frame: 48'h51_0000_0000_55, name: "cmd17"};

    bus.start     = 1'b0;
    bus.cmd_index = '0;
    bus.argument  = '0;
    reset         = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("reset/serial", 64'(bus.serial), 64'd1);
    check("reset/oe",     64'(bus.cmd_oe), 64'd0);
    check("reset/busy",   64'(bus.busy),   64'd0);
    check("reset/done",   64'(bus.done),   64'd0);

    @(negedge sd_clock);
    @(negedge sd_clock);
    reset = 1'b1;

    // First start right after reset release, then back-to-back known commands.
    for (int v = 0; v < 3; v++)
      run_frame(vecs[v].idx, vecs[v].arg, vecs[v].frame, vecs[v].name, -1, 1'b0, -1);

    // Starts at bit 20 and in DONE are ignored; a start in the next IDLE cycle is honoured.
    run_frame(vecs[1].idx, vecs[1].arg, vecs[1].frame, "ignore_start", 20, 1'b1, -1);
    run_frame(vecs[2].idx, vecs[2].arg, vecs[2].frame, "after_ignore", -1, 1'b0, -1);

    for (int r = 0; r < 6; r++) begin
      ridx = 6'($urandom_range(0, 63));
      rarg = $urandom;
      run_frame(ridx, rarg, model_frame(ridx, rarg), "random", -1, 1'b0, -1);
    end

    // Asynchronous reset at bit 30, then confirm the aborted frame never completes.
    ridx = 6'd5;
    rarg = $urandom;
    run_frame(ridx, rarg, model_frame(ridx, rarg), "midreset", -1, 1'b0, 30);
    repeat (3) @(negedge sd_clock);
    reset = 1'b1;
    seen  = 1'b0;
    repeat (60) begin
      @(negedge sd_clock);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_oe !== 1'b0) seen = 1'b1;
    end
    check("midreset/no_resume", 64'(seen), 64'd0);
    run_frame(vecs[0].idx, vecs[0].arg, vecs[0].frame, "cmd0_after_reset", -1, 1'b0, -1);
    bus.start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
